// File: rtl/divrem_seq32.sv
// divrem_seq32: RISC-V DIV/DIVU/REM/REMU sequencer around a 32-bit unsigned restoring divider core.
// Define DIVREM_REUSE_EN to reuse the last core result for a repeated operand pair.
//
// state | meaning
// IDLE  | ready for a request, special cases resolved here
// START | one-cycle core_start pulse
// CHECK | first cycle after start, detects the core a<b short path
// WAIT  | core busy, capture on the first idle cycle
// FIX   | sign fix-up and quotient/remainder select
// RESP  | response held until resp_ready
// DRAIN | flushed, waiting for the core to go idle

module divrem_seq32 #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstLow,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      core_a,
  output logic [31:0]      core_b,
  output logic             core_start,
  input  logic             core_busy,
  input  logic [31:0]      core_q,
  input  logic [31:0]      core_r
);

  typedef enum logic [2:0] {IDLE, START, CHECK, WAIT, FIX, RESP, DRAIN} state_t;

  function automatic logic [31:0] negate(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  state_t           state_q, state_d;
  logic             rem_sel_q, rem_sel_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [31:0]      core_a_q, core_a_d;
  logic [31:0]      core_b_q, core_b_d;
  logic             core_start_q, core_start_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      rem_q, rem_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

  logic        accept, req_signed, neg_a, neg_b, div_zero, sgn_ovf;
  logic [31:0] mag_a, mag_b, quo_fix, rem_fix;
  logic        reuse_hit;
  logic [31:0] reuse_data;

  assign req_signed = ~req_op[0];
  assign neg_a      = req_signed & req_rs1[31];
  assign neg_b      = req_signed & req_rs2[31];
  assign mag_a      = neg_a ? negate(req_rs1) : req_rs1;
  assign mag_b      = neg_b ? negate(req_rs2) : req_rs2;
  assign div_zero   = (req_rs2 == 32'd0);
  assign sgn_ovf    = req_signed && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
  assign accept     = (state_q == IDLE) && req_valid && !flush;
  assign quo_fix    = neg_quo_q ? negate(quo_q) : quo_q;
  assign rem_fix    = neg_rem_q ? negate(rem_q) : rem_q;

`ifdef DIVREM_REUSE_EN
  logic [31:0] cur_rs1_q, cur_rs1_d, cur_rs2_q, cur_rs2_d;
  logic        cur_signed_q, cur_signed_d;
  logic [31:0] last_rs1_q, last_rs1_d, last_rs2_q, last_rs2_d;
  logic [31:0] last_q_q, last_q_d, last_r_q, last_r_d;
  logic        last_signed_q, last_signed_d, last_vld_q, last_vld_d;

  // Stored results are magnitudes; the sign fix uses the new request's flags.
  assign reuse_hit  = last_vld_q && (req_rs1 == last_rs1_q) && (req_rs2 == last_rs2_q)
                      && (req_signed == last_signed_q);
  assign reuse_data = req_op[1] ? (neg_a ? negate(last_r_q) : last_r_q)
                                : ((neg_a ^ neg_b) ? negate(last_q_q) : last_q_q);

  always_comb begin
    cur_rs1_d     = cur_rs1_q;
    cur_rs2_d     = cur_rs2_q;
    cur_signed_d  = cur_signed_q;
    last_rs1_d    = last_rs1_q;
    last_rs2_d    = last_rs2_q;
    last_signed_d = last_signed_q;
    last_q_d      = last_q_q;
    last_r_d      = last_r_q;
    last_vld_d    = last_vld_q;
    if (accept) begin
      cur_rs1_d    = req_rs1;
      cur_rs2_d    = req_rs2;
      cur_signed_d = req_signed;
    end
    if ((state_q == CHECK || state_q == WAIT) && !core_busy) begin
      last_rs1_d    = cur_rs1_q;
      last_rs2_d    = cur_rs2_q;
      last_signed_d = cur_signed_q;
      last_q_d      = core_q;
      last_r_d      = core_r;
      last_vld_d    = 1'b1;
    end
    if (flush) last_vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      cur_rs1_q     <= '0;
      cur_rs2_q     <= '0;
      cur_signed_q  <= 1'b0;
      last_rs1_q    <= '0;
      last_rs2_q    <= '0;
      last_signed_q <= 1'b0;
      last_q_q      <= '0;
      last_r_q      <= '0;
      last_vld_q    <= 1'b0;
    end else begin
      cur_rs1_q     <= cur_rs1_d;
      cur_rs2_q     <= cur_rs2_d;
      cur_signed_q  <= cur_signed_d;
      last_rs1_q    <= last_rs1_d;
      last_rs2_q    <= last_rs2_d;
      last_signed_q <= last_signed_d;
      last_q_q      <= last_q_d;
      last_r_q      <= last_r_d;
      last_vld_q    <= last_vld_d;
    end
  end
`else
  assign reuse_hit  = 1'b0;
  assign reuse_data = 32'd0;
`endif

  always_comb begin
    state_d      = state_q;
    rem_sel_d    = rem_sel_q;
    neg_quo_d    = neg_quo_q;
    neg_rem_d    = neg_rem_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    core_start_d = 1'b0;
    quo_d        = quo_q;
    rem_d        = rem_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rem_sel_d  = req_op[1];
          neg_quo_d  = neg_a ^ neg_b;
          neg_rem_d  = neg_a;
          resp_tag_d = req_tag;
          if (div_zero) begin
            resp_data_d  = req_op[1] ? req_rs1 : 32'hFFFF_FFFF;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (sgn_ovf) begin
            resp_data_d  = req_op[1] ? 32'd0 : 32'h8000_0000;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (reuse_hit) begin
            resp_data_d  = reuse_data;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            core_a_d     = mag_a;
            core_b_d     = mag_b;
            core_start_d = 1'b1;
            state_d      = START;
          end
        end
      end
      START: state_d = flush ? DRAIN : CHECK;
      CHECK, WAIT: begin
        if (flush) begin
          state_d = DRAIN;
        end else if (!core_busy) begin
          quo_d   = core_q;
          rem_d   = core_r;
          state_d = FIX;
        end else begin
          state_d = WAIT;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          resp_data_d  = rem_sel_q ? rem_fix : quo_fix;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (flush || resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      DRAIN: if (!core_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      state_q      <= IDLE;
      rem_sel_q    <= 1'b0;
      neg_quo_q    <= 1'b0;
      neg_rem_q    <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_start_q <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      rem_sel_q    <= rem_sel_d;
      neg_quo_q    <= neg_quo_d;
      neg_rem_q    <= neg_rem_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_start_q <= core_start_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign core_start = core_start_q;

endmodule

// File: tb/tb_divrem_seq32.sv
// Testbench for divrem_seq32: behavioural divider core, reference model and response scoreboard.
module tb_divrem_seq32;
  localparam int TAG_W = 5;
`ifdef DIVREM_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0, req_ready;
  logic [1:0]       req_op = 2'b00;
  logic [31:0]      req_rs1 = '0, req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             resp_valid, resp_ready = 1'b0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic [31:0]      core_a, core_b, core_q, core_r;
  logic             core_start, core_busy;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               lat;
    int               starts;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0, n_errors = 0;
  int          starts = 0;
  int          core_lat = 3;
  int          busy_cnt;
  bit          m_last_vld = 1'b0;
  bit          m_last_signed = 1'b0;
  logic [31:0] m_last_rs1 = '0, m_last_rs2 = '0;

  always #5 clk = ~clk;

  divrem_seq32 #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rstLow(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
    .core_a(core_a), .core_b(core_b), .core_start(core_start), .core_busy(core_busy),
    .core_q(core_q), .core_r(core_r)
  );

  // Divider core: a<b answers at once, otherwise busy for core_lat cycles after the start pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (core_start && core_a >= core_b) busy_cnt <= core_lat;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign core_busy = (busy_cnt != 0);
  assign core_q = (core_b == 32'd0) ? 32'hFFFF_FFFF : core_a / core_b;
  assign core_r = (core_b == 32'd0) ? core_a : core_a % core_b;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (core_start) begin
      starts++;
      check("start_while_busy", {31'd0, core_busy}, 32'd0);
    end
  end

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int hold);
    exp_t        e;
    logic [31:0] ma, mb, d0;
    logic [TAG_W-1:0] t0;
    bit          special, hit, core_path;
    int          s0, lat, w;
    special   = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit       = REUSE && m_last_vld && a == m_last_rs1 && b == m_last_rs2 && (!op[0]) == m_last_signed;
    ma        = (!op[0] && a[31]) ? (~a) + 32'd1 : a;
    mb        = (!op[0] && b[31]) ? (~b) + 32'd1 : b;
    core_path = !special && !hit;
    e.data    = ref_res(op, a, b);
    e.tag     = tag;
    e.lat     = !core_path ? 1 : ((ma < mb) ? 4 : 4 + core_lat);
    e.starts  = core_path ? 1 : 0;
    sb_q.push_back(e);

    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    check("req_ready", {31'd0, req_ready}, 32'd1);
    s0 = starts;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 100);

    e = sb_q.pop_front();
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("resp_data", resp_data, e.data);
    check("resp_tag", 32'(resp_tag), 32'(e.tag));
    check("latency", 32'(lat), 32'(e.lat));
    check("core_starts", 32'(starts - s0), 32'(e.starts));
    if (core_path) begin
      check("core_a", core_a, ma);
      check("core_b", core_b, mb);
      m_last_vld = 1'b1; m_last_rs1 = a; m_last_rs2 = b; m_last_signed = !op[0];
    end

    d0 = resp_data;
    t0 = resp_tag;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_data", resp_data, d0);
      check("hold_tag", 32'(resp_tag), 32'(t0));
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_drop", {31'd0, resp_valid}, 32'd0);
    check("idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Issues a long DIVU and flushes once the sequencer sits in WAIT.
  task automatic flush_in_wait();
    int s0, i;
    core_lat = 8;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_tag = 5'd7;
    check("flush_req_ready", {31'd0, req_ready}, 32'd1);
    s0 = starts;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush_busy", {31'd0, core_busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    i = 0;
    while (core_busy && i < 50) begin
      check("drain_ready", {31'd0, req_ready}, 32'd0);
      check("drain_no_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      i++;
    end
    check("drain_core_idle", {31'd0, core_busy}, 32'd0);
    @(negedge clk);
    check("drain_to_idle", {31'd0, req_ready}, 32'd1);
    check("drain_no_resp", {31'd0, resp_valid}, 32'd0);
    check("drain_starts", 32'(starts - s0), 32'd1);
    m_last_vld = 1'b0;
    core_lat = 3;
  endtask

  // Asynchronous reset while the core is busy.
  task automatic reset_mid_op();
    core_lat = 8;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd5000; req_rs2 = 32'd7; req_tag = 5'd9;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid_core_a", core_a, 32'd0);
    check("rst_mid_core_b", core_b, 32'd0);
    check("rst_mid_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last_vld = 1'b0;
    core_lat = 3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_core_a", core_a, 32'd0);
    check("rst_core_b", core_b, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b01, 32'd100, 32'd7, 5'd3, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
    run_op(2'b00, 32'd5, 32'd0, 5'd6, 0);
    run_op(2'b11, 32'd5, 32'd0, 5'd7, 0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0);
    run_op(2'b01, 32'd3, 32'd9, 5'd10, 5);
    run_op(2'b00, 32'd100, 32'd7, 5'd11, 0);
    run_op(2'b10, 32'd100, 32'd7, 5'd12, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd13, 0);
    run_op(2'b00, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd14, 0);
    run_op(2'b00, 32'h8000_0000, 32'd2, 5'd15, 0);
    flush_in_wait();
    run_op(2'b00, 32'd100, 32'd7, 5'd16, 0);
    reset_mid_op();
    run_op(2'b10, 32'd100, 32'd7, 5'd17, 0);
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      core_lat = $urandom_range(1, 6);
      run_op(op, a, b, 5'(i), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
